// File: rtl/cp0_irq_ctrl.sv
// cp0_irq_ctrl: sticky maskable interrupts, CP0 Status/Cause/EPC and safe-point interrupt take/ERET FSM
module cp0_irq_ctrl #(
  parameter int          NUM_IRQ      = 8,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0180
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [31:0]        inst_i,
  input  logic               ctrl_flow_e,
  input  logic [31:0]        pc_i,
  input  logic               cop_we,
  input  logic [4:0]         cop_addr,
  input  logic [31:0]        cop_wdata,
  output logic [31:0]        cop_rdata,
  input  logic               eret_e,
  output logic               take_irq,
  output logic [31:0]        handler_pc,
  output logic [31:0]        epc,
  output logic               in_handler
);
  typedef enum logic [1:0] {IDLE, ARMED, HANDLER} stateT;
  stateT state;
  logic [NUM_IRQ-1:0] irqS, ip, im, pending, w1cMask;
  logic ie, req, brI, blocked, wrStatus, wrCause, wrEpc, eretOk;
  logic [2:0] irqId, lowId;
  logic [5:0] op, funct;
  logic [31:0] statusReg, causeReg;
  assign op = inst_i[31:26];
  assign funct = inst_i[5:0];
  assign brI = (op >= 6'h01 && op <= 6'h07) || (op == 6'h00 && (funct == 6'h08 || funct == 6'h09));
  assign blocked = stall | ctrl_flow_e | cop_we | brI;
  assign pending = ip & im;
  assign req = (|pending) & ie;
  assign wrStatus = cop_we & ~stall & (cop_addr == 5'd12);
  assign wrCause = cop_we & ~stall & (cop_addr == 5'd13);
  assign wrEpc = cop_we & ~stall & (cop_addr == 5'd14);
  assign w1cMask = wrCause ? cop_wdata[8 +: NUM_IRQ] : '0;
  assign eretOk = eret_e & ~stall;
  assign take_irq = ~rst & (state == ARMED) & req & ~blocked;
  assign in_handler = (state == HANDLER);
  assign handler_pc = HANDLER_ADDR;
  // Lowest-numbered pending line has the highest priority
  always_comb begin
    lowId = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (pending[i]) lowId = 3'(i);
  end
  always_comb begin
    statusReg = '0;
    statusReg[8 +: NUM_IRQ] = im;
    statusReg[0] = ie;
    causeReg = '0;
    causeReg[8 +: NUM_IRQ] = ip;
    causeReg[4:2] = irqId;
    cop_rdata = cop_addr == 5'd12 ? statusReg :
                cop_addr == 5'd13 ? causeReg :
                cop_addr == 5'd14 ? epc : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      irqS <= '0;
      ip <= '0;
      im <= '0;
      ie <= 1'b0;
      irqId <= '0;
      epc <= '0;
    end else begin
      irqS <= irq_in;
      ip <= (ip & ~w1cMask) | irqS;
      if (wrStatus) begin
        ie <= cop_wdata[0];
        im <= cop_wdata[8 +: NUM_IRQ];
      end
      if (wrEpc) epc <= cop_wdata;
      if (eretOk) ie <= 1'b1;
      if (take_irq) begin
        epc <= pc_i;
        irqId <= lowId;
        ie <= 1'b0;
      end
      state <= state == IDLE  ? (req ? ARMED : IDLE) :
               state == ARMED ? (take_irq ? HANDLER : req ? ARMED : IDLE) :
               (eretOk ? IDLE : HANDLER);
    end
  end
endmodule

// File: doc/cp0_irq_ctrl.md
Name: cp0_irq_ctrl

Overview:
- Parametrised interrupt and coprocessor-0 controller for the 3-stage MIPS pipeline.
- Supersedes the single-line, purely combinational interrupt-accept logic with:
  - NUM_IRQ sticky, maskable interrupt lines
  - fixed-priority selection
  - Status/Cause/EPC registers reachable by MTC0/MFC0
  - a state machine that takes an interrupt only at a safe pipeline point and returns on ERET.
- Sits beside the E-stage decoder. Drives the PC mux to the handler.

Parameters:
- NUM_IRQ, 8, number of interrupt lines (1..8).
- HANDLER_ADDR, 32'h0000_0180, PC loaded when an interrupt is taken.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- stall  in  1  pipeline stall; nothing is taken or retired while high.
- irq_in  in  NUM_IRQ  level interrupt requests, asynchronous to the pipeline.
- inst_i  in  32  instruction in I stage.
- ctrl_flow_e  in  1  jump or branch currently in E stage.
- pc_i  in  32  PC of the instruction in I stage; saved to EPC.
- cop_we  in  1  MTC0 in E.
- cop_addr  in  5  CP0 register number (rd field).
- cop_wdata  in  32  MTC0 data.
- cop_rdata  out  32  MFC0 data, combinational from cop_addr.
- eret_e  in  1  ERET in E.
- take_irq  out  1  one-cycle pulse: redirect PC to handler_pc.
- handler_pc  out  32  equals HANDLER_ADDR.
- epc  out  32  EPC register; ERET target.
- in_handler  out  1  high from take until ERET retires.

Behaviour:
- Input synchroniser:
  - irq_s <= irq_in every cycle (one flop).
  - IP[i] <= IP[i] | irq_s[i].
- CP0 registers (cop_addr):
  - Status (12): bit0 IE; bits[8+NUM_IRQ-1:8] IM.
  - Cause (13): bits[8+NUM_IRQ-1:8] IP; bits[4:2] IRQ_ID.
  - EPC (14): EPC.
  - Any other address reads 0; writes to it are ignored. Unused bits read 0.
- MTC0 writes (applied at the edge where cop_we=1 and stall=0):
  - Status: IE, IM <= wdata.
  - Cause: bits written 1 clear the matching IP bits (W1C). If irq_s is set on the same bit in the same cycle, set wins.
  - EPC: loaded directly.
- Derived signals:
  - pending = IP & IM.
  - req = (|pending) & IE.
- blocked = stall | ctrl_flow_e | cop_we | br_i, where br_i is true for inst_i opcode:
  - 01, 02, 03, 04, 05, 06, 07, or
  - opcode 00 with funct 08/09.
  - The funct check is qualified by opcode 00.
- State machine (IDLE, ARMED, HANDLER):
  - IDLE:
    - req -> ARMED.
  - ARMED:
    - !req -> IDLE; line masked or cleared; no take.
    - req & !blocked -> assert take_irq combinationally this cycle, then at the edge:
      - EPC <= pc_i
      - IRQ_ID <= index of lowest-numbered set pending bit
      - IE <= 0
      - state -> HANDLER.
    - req & blocked -> stay ARMED.
  - HANDLER:
    - in_handler=1; take_irq never asserted.
    - eret_e & !stall -> IE <= 1, state -> IDLE.
    - IP is not auto-cleared; software clears it via Cause W1C.
- Latency: irq_in rising before edge N sets IP at edge N+1 and reaches ARMED at edge N+2. take_irq can assert in the cycle after edge N+2.
- Reset (sync):
  - state IDLE; IE=0; IM=0; IP=0; IRQ_ID=0; EPC=0; irq_s=0.
  - take_irq=0; in_handler=0.
  - Reset mid-handler or mid-ARMED returns to IDLE immediately; no take that cycle.
- Simultaneous MTC0 Status and a would-be take: cop_we blocks the take. The new IE/IM are evaluated next cycle.
- eret_e outside HANDLER: sets IE=1 only.

Test Plan:
- Basic take: reset; MTC0 Status=32'h0000_0101; pulse irq_in[0] one cycle; no blocking.
  - Expect IP[0]=1 two edges later, then a take_irq pulse with EPC=pc_i and in_handler=1.
  - Expect handler_pc=32'h0000_0180 and Status read 32'h0000_0100.
- Branch block: ARMED with inst_i=BEQ (opcode 04) for 2 cycles, then ctrl_flow_e=1 for 1 cycle, then a non-branch instruction.
  - Expect take_irq only on the first unblocked cycle.
  - Expect EPC = that cycle's pc_i.
  - Repeat with opcode 00, funct 08: blocked.
  - Repeat with opcode 0x23, funct field 08: not blocked.
- Priority: IM=all, irq_in=8'b1010_0100 simultaneously.
  - Expect Cause[4:2]=2 after take.
  - Expect Cause[15:8]=8'hA4 until cleared.
- Mask / cancel:
  - IM=0 with irq_in[3] high: IP[3] sets, no take.
  - Set IM bit 3: expect take.
  - ARMED then MTC0 Cause W1C 32'h0000_0800 with irq_in low: expect IDLE, no take.
- ERET and nesting:
  - In HANDLER, raise irq_in[1]: expect no take.
  - eret_e with stall=1: expect no change. With stall=0: IE=1 and IDLE.
  - Expect the next take for line 1 two edges later.
- Reset mid-operation: assert rst while in HANDLER with EPC=32'h0000_1234.
  - Next edge: expect in_handler=0, EPC=0, IP=0, cop_rdata for address 12 = 0.
